// File: rtl/simon_4872.sv
// Iterative SIMON block cipher engine (default SIMON 48/96), one round per clock.
// Optional macro SIMON_DECRYPT_EN adds the decrypt path and the stored round-key file.
module simon_4872 #(
    parameter int N  = 24,
    parameter int M  = 4,
    parameter int T  = 36,
    parameter int Co = 6
) (
    input  logic                 clk,
    input  logic                 nR,
    input  logic                 newKey,
    input  logic [M-1:0][N-1:0]  key,
    output logic                 loadKey,
    output logic                 doneKey,
    input  logic                 newData,
    input  logic                 enc_dec,
    input  logic [1:0][N-1:0]    inData,
    output logic                 loadData,
    output logic                 doneData,
    input  logic                 readData,
    output logic [1:0][N-1:0]    outData,
    output logic [3:0]           mode
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        KEYEXP = 4'd1,
        READY  = 4'd2,
        RUN    = 4'd3,
        DONE   = 4'd4
    } stateT;

    localparam logic [61:0] Z0   = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1   = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] ZSEQ = (M == 3) ? Z0 : Z1;
    localparam logic [N-1:0] kConst = {{(N-2){1'b1}}, 2'b00};

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int s);
        return (v >> s) | (v << (N - s));
    endfunction

    function automatic logic [N-1:0] roundF(input logic [N-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // w[0] is the oldest word k[i-M], w[M-1] the newest k[i-1]
    function automatic logic [N-1:0] keyStep(input logic [M-1:0][N-1:0] w, input logic zb);
        logic [N-1:0] tmp;
        tmp = rotr(w[M-1], 3);
        if (M == 4)
            tmp = tmp ^ w[1];
        tmp = tmp ^ rotr(tmp, 1);
        return kConst ^ {{(N-1){1'b0}}, zb} ^ w[0] ^ tmp;
    endfunction

    stateT state, nextState;
    logic capKey, capData, stepKey, stepRound, finKey, finRound, ack;
    logic lastKey, lastRound, keyAdv;
    logic [Co-1:0] cnt;
    logic [5:0] zIdx;
    logic zBit;
    logic [M-1:0][N-1:0] kw;
    logic [N-1:0] xReg, yReg, nx, ny, rkSel, kNew;

    assign mode      = state;
    assign zBit      = ZSEQ[6'd61 - zIdx];
    assign kNew      = keyStep(kw, zBit);
    assign lastRound = (cnt == Co'(T - 1));

`ifdef SIMON_DECRYPT_EN
    logic [N-1:0] rk [T];
    logic encReg;
    logic [Co-1:0] decIdx;

    assign decIdx  = Co'(T - 1) - cnt;
    assign rkSel   = encReg ? rk[cnt] : rk[decIdx];
    assign lastKey = (cnt == Co'(T - 1));
    assign keyAdv  = stepKey;
`else
    logic [M-1:0][N-1:0] keyReg;
    logic unusedEncDec;

    assign unusedEncDec = enc_dec;
    assign rkSel   = kw[0];
    assign lastKey = 1'b1;
    assign keyAdv  = stepRound;
`endif

    always_comb begin
        nx = yReg ^ roundF(xReg) ^ rkSel;
        ny = xReg;
`ifdef SIMON_DECRYPT_EN
        if (!encReg) begin
            nx = yReg;
            ny = xReg ^ roundF(yReg) ^ rkSel;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (nR)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        capKey    = 1'b0;
        capData   = 1'b0;
        stepKey   = 1'b0;
        stepRound = 1'b0;
        finKey    = 1'b0;
        finRound  = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE: begin
                if (newKey) begin
                    capKey    = 1'b1;
                    nextState = KEYEXP;
                end
            end
            KEYEXP: begin
                stepKey = 1'b1;
                if (lastKey) begin
                    finKey    = 1'b1;
                    nextState = READY;
                end
            end
            READY: begin
                if (newKey) begin
                    capKey    = 1'b1;
                    nextState = KEYEXP;
                end else if (newData) begin
                    capData   = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                stepRound = 1'b1;
                if (lastRound) begin
                    finRound  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                if (readData) begin
                    ack       = 1'b1;
                    nextState = READY;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nR) begin
            loadKey  <= 1'b0;
            doneKey  <= 1'b0;
            loadData <= 1'b0;
            doneData <= 1'b0;
            outData  <= '0;
            cnt      <= '0;
            zIdx     <= '0;
        end else begin
            loadKey  <= capKey;
            loadData <= capData;
            if (capKey)
                doneKey <= 1'b0;
            else if (finKey)
                doneKey <= 1'b1;
            if (finRound) begin
                outData  <= {nx, ny};
                doneData <= 1'b1;
            end else if (ack) begin
                doneData <= 1'b0;
            end
            if (capKey)
`ifdef SIMON_DECRYPT_EN
                cnt <= Co'(M);
`else
                cnt <= '0;
`endif
            else if (capData)
                cnt <= '0;
            else if (stepKey || stepRound)
                cnt <= cnt + 1'b1;
            if (capKey || capData)
                zIdx <= '0;
            else if (keyAdv)
                zIdx <= (zIdx == 6'd61) ? 6'd0 : zIdx + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (capData) begin
            xReg <= inData[1];
            yReg <= inData[0];
        end else if (stepRound) begin
            xReg <= nx;
            yReg <= ny;
        end
    end

`ifdef SIMON_DECRYPT_EN
    // Schedule expanded once into the file; the window holds the last M words
    always_ff @(posedge clk) begin
        if (capData)
            encReg <= enc_dec;
        if (capKey)
            kw <= key;
        else if (stepKey)
            kw <= {kNew, kw[M-1:1]};
    end

    always_ff @(posedge clk) begin
        if (capKey) begin
            for (int i = 0; i < M; i++)
                rk[i] <= key[i];
        end else if (stepKey) begin
            rk[cnt] <= kNew;
        end
    end
`else
    // Round keys regenerated on the fly from the saved key each block
    always_ff @(posedge clk) begin
        if (capKey)
            keyReg <= key;
        if (capData)
            kw <= keyReg;
        else if (stepRound)
            kw <= {kNew, kw[M-1:1]};
    end
`endif

endmodule

// File: tb/tb_simon_4872.sv
// Scoreboard bench for simon_4872: driver pushes expected blocks, a monitor
// compares outData and round latency whenever doneData rises.
module tb_simon_4872;

    localparam int N  = 24;
    localparam int M  = 4;
    localparam int T  = 36;
    localparam int Co = 6;
    localparam logic [95:0] KEY = 96'h1A1918_121110_0A0908_020100;
    localparam logic [61:0] Z1B = 62'b10001110111110010011000010110101000111011111001001100001011010;
`ifdef SIMON_DECRYPT_EN
    localparam int KeyLat = T - M;
`else
    localparam int KeyLat = 1;
`endif

    logic clk = 1'b0;
    logic nR, newKey, newData, enc_dec, readData;
    logic [M-1:0][N-1:0] key;
    logic [1:0][N-1:0] inData, outData;
    logic loadKey, doneKey, loadData, doneData;
    logic [3:0] mode;

    int nChk = 0;
    int nPass = 0;
    int cyc = 0;
    logic [47:0] expQ[$];
    logic [47:0] pts[5];
    logic [47:0] cts[5];
    logic [47:0] streamIn[5];
    logic [47:0] streamExp[5];

    simon_4872 #(.N(N), .M(M), .T(T), .Co(Co)) dut (
        .clk(clk), .nR(nR), .newKey(newKey), .key(key), .loadKey(loadKey),
        .doneKey(doneKey), .newData(newData), .enc_dec(enc_dec), .inData(inData),
        .loadData(loadData), .doneData(doneData), .readData(readData),
        .outData(outData), .mode(mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] ff(input logic [23:0] v);
        return ({v[22:0], v[23]} & {v[15:0], v[23:16]}) ^ {v[21:0], v[23:22]};
    endfunction

    function automatic logic [47:0] refSimon(input logic [95:0] k96, input logic [47:0] blk, input logic enc);
        logic [23:0] ks [36];
        logic [23:0] x, y, t, tmp;
        for (int i = 0; i < 4; i++)
            ks[i] = k96[i*24 +: 24];
        for (int i = 4; i < 36; i++) begin
            tmp = {ks[i-1][2:0], ks[i-1][23:3]} ^ ks[i-3];
            tmp = tmp ^ {tmp[0], tmp[23:1]};
            ks[i] = ~ks[i-4] ^ tmp ^ {23'd0, Z1B[65-i]} ^ 24'd3;
        end
        x = blk[47:24];
        y = blk[23:0];
        if (enc) begin
            for (int i = 0; i < 36; i++) begin
                t = x;
                x = y ^ ff(x) ^ ks[i];
                y = t;
            end
        end else begin
            for (int i = 35; i >= 0; i--) begin
                t = y;
                y = x ^ ff(y) ^ ks[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    function automatic logic [47:0] expOf(input logic [47:0] blk, input logic enc);
`ifdef SIMON_DECRYPT_EN
        return refSimon(KEY, blk, enc);
`else
        return refSimon(KEY, blk, 1'b1 | enc);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChk++;
        if (act === exp)
            nPass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return loadData;
            1:       return doneData;
            default: return doneKey;
        endcase
    endfunction

    task automatic waitFor(input int sel, input string nm, output int n);
        n = 0;
        while (sig(sel) !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (sig(sel) !== 1'b1) begin
            nChk++;
            $display("FAIL %s: timeout after %0d cycles", nm, n);
        end
    endtask

    // Monitor: one scoreboard pop per doneData rising edge
    logic prevDone = 1'b0;
    logic prevLoad = 1'b0;
    int loadCyc = 0;
    logic [47:0] e;
    always @(negedge clk) begin
        if (loadData === 1'b1 && prevLoad !== 1'b1)
            loadCyc = cyc;
        if (doneData === 1'b1 && prevDone !== 1'b1) begin
            if (expQ.size() == 0) begin
                nChk++;
                $display("FAIL sb_underflow: got outData %0h with nothing expected", outData);
            end else begin
                e = expQ.pop_front();
                check("outData", 64'(outData), 64'(e));
                check("lat_done", 64'(cyc - loadCyc), 64'(T));
            end
        end
        prevLoad = loadData;
        prevDone = doneData;
    end

    task automatic runBlock(input logic [47:0] blk, input logic enc, input logic [47:0] exp, input int rdLat);
        int n;
        expQ.push_back(exp);
        inData = blk;
        enc_dec = enc;
        newData = 1'b1;
        waitFor(0, "blk_load", n);
        newData = 1'b0;
        check("mode_run", 64'(mode), 64'd3);
        tick();
        check("load_pulse", 64'(loadData), 64'd0);
        waitFor(1, "blk_done", n);
        check("mode_done", 64'(mode), 64'd4);
        repeat (rdLat) tick();
        readData = 1'b1;
        tick();
        readData = 1'b0;
        check("done_fall", 64'(doneData), 64'd0);
        check("mode_ready", 64'(mode), 64'd2);
    endtask

    task automatic runStream(input logic enc);
        int n;
        inData = streamIn[0];
        enc_dec = enc;
        newData = 1'b1;
        expQ.push_back(streamExp[0]);
        for (int b = 0; b < 5; b++) begin
            waitFor(0, "stream_load", n);
            newData = 1'b0;
            waitFor(1, "stream_done", n);
            tick();
            if (b < 4) begin
                inData = streamIn[b+1];
                newData = 1'b1;
                expQ.push_back(streamExp[b+1]);
            end
            tick();
            tick();
            check("stream_hold", 64'({loadData, doneData}), 64'd1);
            readData = 1'b1;
            tick();
            readData = 1'b0;
            check("stream_fall", 64'(doneData), 64'd0);
            if (b < 4) begin
                tick();
                check("stream_reload", 64'(loadData), 64'd1);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        nR = 1'b1; newKey = 1'b0; newData = 1'b0; enc_dec = 1'b1; readData = 1'b0;
        key = '0; inData = '0;
        pts[0] = 48'h72696320646E; pts[1] = 48'h000000000000; pts[2] = 48'hFFFFFFFFFFFF;
        pts[3] = 48'h123456789ABC; pts[4] = 48'h800000000001;
        for (int i = 0; i < 5; i++)
            cts[i] = refSimon(KEY, pts[i], 1'b1);
        repeat (3) tick();
        nR = 1'b0;
        check("rst_mode", 64'(mode), 64'd0);
        check("rst_out", 64'(outData), 64'd0);
        check("rst_flags", 64'({loadKey, doneKey, loadData, doneData}), 64'd0);

        // Key expansion timing
        key = KEY;
        newKey = 1'b1;
        tick();
        newKey = 1'b0;
        check("key_loadKey", 64'(loadKey), 64'd1);
        check("key_mode", 64'(mode), 64'd1);
        check("key_doneKey_clr", 64'(doneKey), 64'd0);
        tick();
        check("key_pulse", 64'(loadKey), 64'd0);
        waitFor(2, "key_done", n);
        check("key_lat", 64'(n + 1), 64'(KeyLat));
        check("key_mode_ready", 64'(mode), 64'd2);

        // Known-answer vectors
        runBlock(48'h72696320646E, 1'b1, 48'h6E06A5ACF156, 2);
`ifdef SIMON_DECRYPT_EN
        runBlock(48'h6E06A5ACF156, 1'b0, 48'h72696320646E, 0);
`else
        runBlock(48'h6E06A5ACF156, 1'b0, refSimon(KEY, 48'h6E06A5ACF156, 1'b1), 0);
`endif

        // Back-to-back streams: encrypt, then decrypt the ciphertexts
        for (int i = 0; i < 5; i++) begin
            streamIn[i] = pts[i];
            streamExp[i] = cts[i];
        end
        runStream(1'b1);
        for (int i = 0; i < 5; i++) begin
            streamIn[i] = cts[i];
            streamExp[i] = expOf(cts[i], 1'b0);
        end
        runStream(1'b0);

        // Reset in the middle of a block
        inData = pts[1];
        enc_dec = 1'b1;
        newData = 1'b1;
        waitFor(0, "rst_load", n);
        newData = 1'b0;
        repeat (10) tick();
        nR = 1'b1;
        tick();
        nR = 1'b0;
        check("midrst_mode", 64'(mode), 64'd0);
        check("midrst_out", 64'(outData), 64'd0);
        check("midrst_flags", 64'({loadKey, doneKey, loadData, doneData}), 64'd0);
        newData = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (loadData === 1'b1) seen = 1'b1;
        end
        newData = 1'b0;
        check("nokey_noload", 64'(seen), 64'd0);
        check("nokey_mode", 64'(mode), 64'd0);

        // Reload the key, then newKey and newData together in READY
        newKey = 1'b1;
        tick();
        newKey = 1'b0;
        check("reload_loadKey", 64'(loadKey), 64'd1);
        waitFor(2, "reload_done", n);
        expQ.push_back(cts[3]);
        inData = pts[3];
        enc_dec = 1'b1;
        newKey = 1'b1;
        newData = 1'b1;
        tick();
        newKey = 1'b0;
        check("prio_loadKey", 64'(loadKey), 64'd1);
        check("prio_noLoadData", 64'(loadData), 64'd0);
        check("prio_mode", 64'(mode), 64'd1);
        waitFor(2, "prio_doneKey", n);
        check("prio_wait", 64'(loadData), 64'd0);
        tick();
        check("prio_loadData", 64'(loadData), 64'd1);
        newData = 1'b0;
        waitFor(1, "prio_done", n);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        tick();
        check("sb_empty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
